// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the handshaked sequential ALU (alu_seq).
package alu_seq_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SLT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative signed shift-add multiplier: one partial product per cycle,
// product ready DATA_W cycles after start; done stays high until the next start.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = 2 * DATA_W,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [RES_W-1:0]  p
);

  logic [RES_W-1:0]  r_mcand;
  logic [RES_W-1:0]  r_acc;
  logic [RES_W-1:0]  w_acc_next;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;

  // The final partial product carries b's sign weight, so it is subtracted.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = (r_cnt == CNT_W'(1)) ? (r_acc - r_mcand) : (r_acc + r_mcand);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{(RES_W-DATA_W){a[DATA_W-1]}}, a};
      r_acc    <= '0;
      r_mplier <= b;
      r_cnt    <= CNT_W'(DATA_W);
      r_done   <= 1'b0;
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
      r_done   <= (r_cnt == CNT_W'(1));
    end
  end

  assign done = r_done;
  assign p    = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked signed ALU: single-cycle ops plus an iterative multiply, result held until taken.
// Define ALU_SEQ_SAT_EN to saturate ADD/SUB to DATA_W and expose the sticky ovf flag.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int RES_W  = 2 * DATA_W,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  r,
  output logic              busy
`ifdef ALU_SEQ_SAT_EN
  ,
  output logic              ovf
`endif
);

  localparam int EXT_W = RES_W - DATA_W;

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [RES_W-1:0] r_res, w_res_next;
  logic             r_out_valid, w_valid_next;
  logic             w_accept, w_start, w_mul_done;
  logic [RES_W-1:0] w_mul_p;
  logic [RES_W-1:0] w_single;
  logic [DATA_W:0]  w_sum, w_diff;
  logic [DATA_W-1:0] w_bits;

  assign w_sum  = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign w_diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};

`ifdef ALU_SEQ_SAT_EN
  logic              r_ovf, w_ovf_next, w_sat;
  logic [DATA_W-1:0] w_sum_sat, w_diff_sat;

  // Overflow of the DATA_W range shows as the two top bits of the wide result disagreeing.
  function automatic logic [DATA_W-1:0] sat_w(input logic [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1]) begin
      return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return v[DATA_W-1:0];
  endfunction

  assign w_sum_sat  = sat_w(w_sum);
  assign w_diff_sat = sat_w(w_diff);
`endif

  always_comb begin
    w_single = '0;
    w_bits   = '0;
`ifdef ALU_SEQ_SAT_EN
    w_sat    = 1'b0;
`endif
    case (op)
`ifdef ALU_SEQ_SAT_EN
      OP_ADD: begin
        w_single = {{EXT_W{w_sum_sat[DATA_W-1]}}, w_sum_sat};
        w_sat    = (w_sum[DATA_W] != w_sum[DATA_W-1]);
      end
      OP_SUB: begin
        w_single = {{EXT_W{w_diff_sat[DATA_W-1]}}, w_diff_sat};
        w_sat    = (w_diff[DATA_W] != w_diff[DATA_W-1]);
      end
`else
      OP_ADD:  w_single = {{(EXT_W-1){w_sum[DATA_W]}}, w_sum};
      OP_SUB:  w_single = {{(EXT_W-1){w_diff[DATA_W]}}, w_diff};
`endif
      OP_AND: begin
        w_bits   = a & b;
        w_single = {{EXT_W{w_bits[DATA_W-1]}}, w_bits};
      end
      OP_OR: begin
        w_bits   = a | b;
        w_single = {{EXT_W{w_bits[DATA_W-1]}}, w_bits};
      end
      OP_XOR: begin
        w_bits   = a ^ b;
        w_single = {{EXT_W{w_bits[DATA_W-1]}}, w_bits};
      end
      OP_SLT:  w_single = {{(RES_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASS: w_single = {{EXT_W{a[DATA_W-1]}}, a};
      default: w_single = '0;
    endcase
  end

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_res_next   = r_res;
    w_valid_next = r_out_valid;
    w_start      = 1'b0;
`ifdef ALU_SEQ_SAT_EN
    w_ovf_next   = r_ovf;
`endif
    case (r_state)
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else if (w_mul_done) begin
          w_state_next = DONE;
          w_res_next   = w_mul_p;
          w_valid_next = 1'b1;
        end
      end
      IDLE, DONE: begin
        if ((r_state == DONE) && out_ready) begin
          w_state_next = IDLE;
          w_valid_next = 1'b0;
        end
        // A DONE-state accept overrides the drain above, so results stream without a bubble.
        if (w_accept) begin
          if (op == OP_MUL) begin
            w_state_next = BUSY;
            w_cnt_next   = CNT_W'(DATA_W);
            w_start      = 1'b1;
            w_valid_next = 1'b0;
          end else begin
            w_state_next = DONE;
            w_res_next   = w_single;
            w_valid_next = 1'b1;
`ifdef ALU_SEQ_SAT_EN
            w_ovf_next   = r_ovf | w_sat;
`endif
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
`ifdef ALU_SEQ_SAT_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_res       <= w_res_next;
      r_out_valid <= w_valid_next;
`ifdef ALU_SEQ_SAT_EN
      r_ovf       <= w_ovf_next;
`endif
    end
  end

  alu_seq_mul #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .CNT_W  (CNT_W)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .a     (a),
    .b     (b),
    .done  (w_mul_done),
    .p     (w_mul_p)
  );

  assign out_valid = r_out_valid;
  assign r         = r_res;
  assign busy      = (r_state == BUSY);
`ifdef ALU_SEQ_SAT_EN
  assign ovf       = r_ovf;
`endif

endmodule
